// File: rtl/serial_bit_feeder_pkg.sv
// Shared types and limits for the serial bit feeder.
// Optional build macro SERIAL_FEEDER_LSB_FIRST_EN is consumed by the top module, not here.
package serial_feeder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_SHIFT = 1'(SHIFT);

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Word-in / bit-out handshake bundle between an upstream word source and the feeder.
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             word_done;

    modport master (
        output din, din_valid,
        input  din_ready, bit_out, bit_valid, word_done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, bit_out, bit_valid, word_done
    );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: one WIDTH-bit word in, one bit per clock out, gapless back-to-back.
// Build macro SERIAL_FEEDER_LSB_FIRST_EN selects LSB-first emission (default MSB-first).
module serial_bit_feeder
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    serial_bit_feeder_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
        $fatal(1, "serial_bit_feeder: WIDTH %0d outside legal range", WIDTH);
    end

    logic [0:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] load_word;
    logic             last_bit;
    logic             accept;

    // The register always shifts toward its MSB; bit order is fixed at load time.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_load_order
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
        assign load_word[gi] = bus.din[WIDTH-1-gi];
`else
        assign load_word[gi] = bus.din[gi];
`endif
    end

    assign last_bit = (state_reg == ST_SHIFT) && (cnt_reg == LAST);
    assign accept   = bus.din_valid && bus.din_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        shift_reg <= load_word;
                        cnt_reg   <= '0;
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_reg == LAST) begin
                        cnt_reg <= '0;
                        if (accept) begin
                            shift_reg <= load_word;
                        end else begin
                            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                        cnt_reg   <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    shift_reg <= '0;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so din_valid never reaches them combinationally.
    assign bus.din_ready = (state_reg == ST_IDLE) || last_bit;
    assign bus.bit_valid = (state_reg == ST_SHIFT);
    assign bus.bit_out   = (state_reg == ST_SHIFT) && shift_reg[WIDTH-1];
    assign bus.word_done = last_bit;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Self-checking bench for serial_bit_feeder: directed table, corner sequences and a random run.
module tb_serial_bit_feeder;

    localparam int W = 8;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    serial_bit_feeder_if #(.WIDTH(W)) bus ();

    serial_bit_feeder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: queue of bits still to appear on bit_out; q[0] is the bit on the wire now.
    logic q[$];
    logic s_ready, s_valid;

    function automatic logic bit_at(logic [W-1:0] w, int k);
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
        return w[k];
`else
        return w[W-1-k];
`endif
    endfunction

    function automatic logic [3:0] model_out();
        logic [3:0] r;
        r[3] = (q.size() <= 1);
        r[2] = (q.size() != 0);
        r[1] = (q.size() != 0) ? q[0] : 1'b0;
        r[0] = (q.size() == 1);
        return r;
    endfunction

    function automatic logic [3:0] dut_out();
        return {bus.din_ready, bus.bit_valid, bus.bit_out, bus.word_done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] d);
        logic acc;
        acc = v && (q.size() <= 1);
        if (q.size() != 0) void'(q.pop_front());
        if (acc) begin
            for (int k = 0; k < W; k++) q.push_back(bit_at(d, k));
            $display("txn: word %02h accepted at cycle %0d", d, cyc);
        end
    endtask

    // Called at a negedge: check, drive, clock, update model, return at next negedge.
    task automatic cycle(input logic v, input logic [W-1:0] d);
        s_ready = bus.din_ready;
        s_valid = bus.bit_valid;
        chk("model_cmp {ready,valid,bit,done}", 32'(dut_out()), 32'(model_out()));
        bus.din_valid = v;
        bus.din       = d;
        @(posedge clk);
        model_edge(v, d);
        cyc++;
        @(negedge clk);
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic [3:0]   exp;
    } vec_t;

    vec_t tbl[10];
    int   n_valid, n_ready;

    initial begin
        reset         = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;

        // Reset values while reset is held low
        #1;
        chk("reset_outputs", 32'(dut_out()), 32'b1000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Idle: no valid for 10 cycles, random din must be ignored
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, W'($urandom));
            chk("idle_outputs", 32'(dut_out()), 32'b1000);
        end

        // Directed table: one 8'hAA word with a single-cycle valid
        tbl[0] = '{v: 1'b1, d: 8'hAA, exp: 4'b1000};
        for (int k = 1; k <= 8; k++)
            tbl[k] = '{v: 1'b0, d: 8'h00,
                       exp: {(k == 8), 1'b1, bit_at(8'hAA, k - 1), (k == 8)}};
        tbl[9] = '{v: 1'b0, d: 8'h00, exp: 4'b1000};
        n_valid = 0;
        for (int i = 0; i < 10; i++) begin
            chk("table_vec", 32'(dut_out()), 32'(tbl[i].exp));
            cycle(tbl[i].v, tbl[i].d);
            n_valid += int'(s_valid);
        end
        chk("single_word_valid_cycles", 32'(n_valid), 32'd8);

        // Back-to-back: A0 then 5A with valid held
        n_valid = 0;
        n_ready = 0;
        cycle(1'b1, 8'hA0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'h5A);
            n_valid += int'(s_valid);
            n_ready += int'(s_valid && s_ready);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'h00);
            n_valid += int'(s_valid);
            n_ready += int'(s_valid && s_ready);
        end
        chk("b2b_valid_cycles", 32'(n_valid), 32'd16);
        chk("b2b_ready_while_shifting", 32'(n_ready), 32'd2);

        // Stall: new word offered at bit 3, din changed before acceptance
        n_valid = 0;
        cycle(1'b1, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'hFF);
            n_valid += int'(s_valid);
        end
        cycle(1'b1, 8'h11);
        n_valid += int'(s_valid);
        chk("stall_not_ready", 32'(bus.din_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'hC3);
            n_valid += int'(s_valid);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'h00);
            n_valid += int'(s_valid);
        end
        chk("stall_valid_cycles_no_gap", 32'(n_valid), 32'd16);

        // Reset mid-word at bit 4 of 8'hFF; a valid offered during reset must be ignored
        cycle(1'b1, 8'hFF);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00);
        chk("pre_reset_bit", 32'(dut_out()), 32'(model_out()));
        #2;
        reset         = 1'b0;
        bus.din_valid = 1'b1;
        bus.din       = 8'hAA;
        #1;
        chk("async_reset_outputs", 32'(dut_out()), 32'b1000);
        q.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("reset_held_outputs", 32'(dut_out()), 32'b1000);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00);
            chk("post_reset_idle", 32'(dut_out()), 32'b1000);
        end

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 9) < 4), W'($urandom));
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
